// File: rtl/count_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package count_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Loads above the modulus are pulled down to the top count value.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Tick prescaler for count_updown_mod: one tick every PRESCALE enabled cycles.
// Only compiled when COUNT_PRESCALE_EN is defined.
`ifdef COUNT_PRESCALE_EN
module count_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en && (phase == LAST);

  // Phase only advances on enabled cycles, so gaps in en preserve it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/count_updown_mod.sv
// Width-generic modulo-N up/down counter with load, terminal-count pulse and
// saturating wrap counter. Define COUNT_PRESCALE_EN to step only every PRESCALE enabled cycles.
module count_updown_mod
  import count_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 255,
  parameter int WRAP_W   = 8,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count_out,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

  if ((MOD_MAX < 1) || (MOD_MAX > (2**WIDTH) - 1) || (PRESCALE < 1)) begin : g_param_check
    $fatal(1, "count_updown_mod: illegal MOD_MAX or PRESCALE");
  end

  logic tick;

`ifdef COUNT_PRESCALE_EN
  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );
`else
  assign tick = en;
`endif

  // Load beats step beats hold; tc is high only on the edge that wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
      tc        <= 1'b0;
      wrap_cnt  <= '0;
    end else if (load) begin
      count_out <= WIDTH'(clamp_load(32'(load_val), 32'(MOD_MAX)));
      tc        <= 1'b0;
      wrap_cnt  <= '0;
    end else if (tick) begin
      tc <= 1'b0;
      case (up_dn)
        DIR_UP: begin
          if (count_out == MAX_V) begin
            count_out <= '0;
            tc        <= 1'b1;
            if (wrap_cnt != {WRAP_W{1'b1}}) wrap_cnt <= wrap_cnt + 1'b1;
          end else begin
            count_out <= count_out + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (count_out == '0) begin
            count_out <= MAX_V;
            tc        <= 1'b1;
            if (wrap_cnt != {WRAP_W{1'b1}}) wrap_cnt <= wrap_cnt + 1'b1;
          end else begin
            count_out <= count_out - 1'b1;
          end
        end
      endcase
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_updown_mod.sv
// Scoreboard bench for count_updown_mod: directed vectors push expectations, a monitor pops and checks.
module tb_count_updown_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up_dn, load;
  logic [7:0] load_val;
  logic [7:0] count_out;
  logic       tc;
  logic [7:0] wrap_cnt;

  logic       en_s, up_s, load_s;
  logic [7:0] lv_s;
  logic [7:0] count_s;
  logic       tc_s;
  logic [1:0] wrap_s;

  typedef struct {
    int         unit;
    logic [7:0] cnt;
    logic       tc;
    logic [7:0] wrap;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  count_updown_mod #(
    .WIDTH(8), .MOD_MAX(9), .WRAP_W(8), .PRESCALE(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count_out(count_out),
    .tc       (tc),
    .wrap_cnt (wrap_cnt)
  );

  count_updown_mod #(
    .WIDTH(8), .MOD_MAX(1), .WRAP_W(2), .PRESCALE(1)
  ) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s),
    .up_dn    (up_s),
    .load     (load_s),
    .load_val (lv_s),
    .count_out(count_s),
    .tc       (tc_s),
    .wrap_cnt (wrap_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and queues the state expected after the next rising edge.
  task automatic applyStimulus(input int unit, input int l, input int e, input int u, input int lv,
                               input int ec, input int et, input int ew, input string tag);
    exp_t x;
    if (unit == 0) begin
      load = 1'(l); en = 1'(e); up_dn = 1'(u); load_val = 8'(lv);
      load_s = 1'b0; en_s = 1'b0;
    end else begin
      load_s = 1'(l); en_s = 1'(e); up_s = 1'(u); lv_s = 8'(lv);
      load = 1'b0; en = 1'b0;
    end
    x.unit = unit; x.cnt = 8'(ec); x.tc = 1'(et); x.wrap = 8'(ew); x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.unit == 0) begin
          checkOutput({mon_e.tag, " count"}, 32'(count_out), 32'(mon_e.cnt));
          checkOutput({mon_e.tag, " tc"},    32'(tc),        32'(mon_e.tc));
          checkOutput({mon_e.tag, " wrap"},  32'(wrap_cnt),  32'(mon_e.wrap));
        end else begin
          checkOutput({mon_e.tag, " count"}, 32'(count_s), 32'(mon_e.cnt));
          checkOutput({mon_e.tag, " tc"},    32'(tc_s),    32'(mon_e.tc));
          checkOutput({mon_e.tag, " wrap"},  32'(wrap_s),  32'(mon_e.wrap));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'd0;
    en_s = 1'b0; up_s = 1'b1; load_s = 1'b0; lv_s = 8'd0;
    #12;
    checkOutput("reset count",     32'(count_out), 0);
    checkOutput("reset tc",        32'(tc),        0);
    checkOutput("reset wrap",      32'(wrap_cnt),  0);
    checkOutput("reset sat count", 32'(count_s),   0);
    checkOutput("reset sat wrap",  32'(wrap_s),    0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef COUNT_PRESCALE_EN
    for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 1, 1, 0, i / 4, 0, 0, $sformatf("p1 cyc%0d", i));
    applyStimulus(0, 0, 1, 1, 0, 4, 0, 0, "p2 en a");
    applyStimulus(0, 0, 1, 1, 0, 4, 0, 0, "p2 en b");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 4, 0, 0, $sformatf("p2 gap%0d", i));
    applyStimulus(0, 0, 1, 1, 0, 4, 0, 0, "p2 en c");
    applyStimulus(0, 0, 1, 1, 0, 5, 0, 0, "p2 phase kept");
    applyStimulus(0, 1, 1, 1, 2, 2, 0, 0, "p3 load");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 2, 0, 0, $sformatf("p3 restart%0d", i));
    applyStimulus(0, 0, 1, 1, 0, 3, 0, 0, "p3 first tick");
`else
    for (int i = 1; i <= 11; i++)
      applyStimulus(0, 0, 1, 1, 0, i % 10, int'(i == 10), int'(i >= 10), $sformatf("t1 up%0d", i));

    applyStimulus(0, 1, 0, 0, 3, 3, 0, 0, "t2 load3");
    applyStimulus(0, 0, 1, 0, 0, 2, 0, 0, "t2 dn2");
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, "t2 dn1");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, "t2 dn0");
    applyStimulus(0, 0, 1, 0, 0, 9, 1, 1, "t2 dn wrap");
    applyStimulus(0, 0, 1, 0, 0, 8, 0, 1, "t2 dn8");
    applyStimulus(0, 1, 0, 0, 200, 9, 0, 0, "t2 clamp");

    applyStimulus(0, 1, 1, 1, 5, 5, 0, 0, "t3 load wins");
    applyStimulus(0, 0, 1, 1, 0, 6, 0, 0, "t3 en1 a");
    applyStimulus(0, 0, 0, 0, 0, 6, 0, 0, "t3 hold a");
    applyStimulus(0, 0, 1, 1, 0, 7, 0, 0, "t3 en1 b");
    applyStimulus(0, 0, 0, 0, 0, 7, 0, 0, "t3 hold b");
    applyStimulus(0, 0, 1, 1, 0, 8, 0, 0, "t3 en1 c");
    applyStimulus(0, 0, 1, 1, 0, 9, 0, 0, "t3 en1 d");
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 1, "t3 wrap");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, "t3 tc drop");

    for (int i = 1; i <= 6; i++) applyStimulus(0, 0, 1, 1, 0, i, 0, 1, $sformatf("t4 up%0d", i));
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4 async count", 32'(count_out), 0);
    checkOutput("t4 async tc",    32'(tc),        0);
    checkOutput("t4 async wrap",  32'(wrap_cnt),  0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 0, "t4 first edge");
    applyStimulus(0, 0, 1, 1, 0, 2, 0, 0, "t4 second edge");

    for (int i = 1; i <= 12; i++)
      applyStimulus(1, 0, 1, 1, 0, i % 2, int'(i % 2 == 0), ((i / 2) > 3) ? 3 : (i / 2),
                    $sformatf("t5 sat%0d", i));
`endif

    load = 1'b0; en = 1'b0; load_s = 1'b0; en_s = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
